// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types: data word, data-cache controller state
//               encoding and the address the hit counter is stored to.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WB         = 3'd1,
        FILL       = 3'd2,
        FLUSH_SCAN = 3'd3,
        FLUSH_WB   = 3'd4,
        CNT_WR     = 3'd5,
        DONE       = 3'd6
    } assoc_dcache_state_t;

    localparam word_t HIT_COUNT_ADDR = 32'h0000_3100;

endpackage
`default_nettype wire

// File: rtl/assoc_dcache_way.sv
`default_nettype none
// ============================================================================
// Module      : assoc_dcache_way
// Description : One way of the set-associative data cache: per-set line
//               storage (valid/dirty/tag/data), tag compare and a
//               synchronous write port for data words and line metadata.
// Revision    : 1.0 - initial release
// ============================================================================
module assoc_dcache_way
    import cpu_types_pkg::*;
#(
    parameter  int SETS  = 8,
    parameter  int WORDS = 2,
    localparam int IB    = $clog2(SETS),
    localparam int OB    = $clog2(WORDS),
    localparam int TB    = 30 - IB - OB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IB-1:0] i_idx,
    input  logic [TB-1:0] i_tag,
    input  logic [OB-1:0] i_roff,
    input  logic          i_wr_en,
    input  logic [OB-1:0] i_wr_off,
    input  word_t         i_wr_data,
    input  logic          i_meta_en,
    input  logic          i_meta_valid,
    input  logic          i_meta_dirty,
    input  logic [TB-1:0] i_meta_tag,
    output logic          o_hit,
    output logic          o_valid,
    output logic          o_dirty,
    output logic [TB-1:0] o_tag,
    output word_t         o_rdata
);

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [TB-1:0]          tag;
        logic [WORDS-1:0][31:0] data;
    } line_t;

    line_t r_line [SETS];

    // Line storage; only valid/dirty are cleared by reset, data/tag are don't-care until filled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                r_line[i].valid <= 1'b0;
                r_line[i].dirty <= 1'b0;
            end
        end else begin
            if (i_meta_en) begin
                r_line[i_idx].valid <= i_meta_valid;
                r_line[i_idx].dirty <= i_meta_dirty;
                r_line[i_idx].tag   <= i_meta_tag;
            end
            if (i_wr_en) begin
                r_line[i_idx].data[i_wr_off] <= i_wr_data;
            end
        end
    end

    // Combinational lookup of the selected set
    always_comb begin
        o_valid = r_line[i_idx].valid;
        o_dirty = r_line[i_idx].dirty;
        o_tag   = r_line[i_idx].tag;
        o_rdata = r_line[i_idx].data[i_roff];
        o_hit   = r_line[i_idx].valid && (r_line[i_idx].tag == i_tag);
    end

endmodule
`default_nettype wire

// File: rtl/assoc_dcache.sv
`default_nettype none
// ============================================================================
// Module      : assoc_dcache
// Description : 2-way set-associative write-back/write-allocate data cache
//               with per-set LRU and a dirty-line flush on halt.
//               Optional feature macro: DCACHE_HITCNT_EN - counts hits and
//               stores the total to HIT_COUNT_ADDR after the flush.
// Revision    : 1.0 - initial release
// ============================================================================
module assoc_dcache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WORDS = 2
) (
    input  logic  CLK,
    input  logic  rst,
    input  logic  halt,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  word_t dmemaddr,
    input  word_t dmemstore,
    output logic  dhit,
    output word_t dmemload,
    output logic  flushed,
    output logic  dREN,
    output logic  dWEN,
    output word_t daddr,
    output word_t dstore,
    input  word_t dload,
    input  logic  dwait
);

    localparam int IB = $clog2(SETS);
    localparam int OB = $clog2(WORDS);
    localparam int TB = 30 - IB - OB;

`ifdef DCACHE_HITCNT_EN
    localparam assoc_dcache_state_t c_FLUSH_END = CNT_WR;
`else
    localparam assoc_dcache_state_t c_FLUSH_END = DONE;
`endif

    assoc_dcache_state_t r_state;
    logic [OB-1:0]       r_wc;
    logic                r_victim;
    logic [IB-1:0]       r_fset;
    logic                r_fway;
    logic [SETS-1:0]     r_lru;
`ifdef DCACHE_HITCNT_EN
    word_t               r_hitcnt;
    logic                r_after_fill;
`endif

    logic [TB-1:0] w_req_tag;
    logic [IB-1:0] w_req_idx;
    logic [OB-1:0] w_req_off;
    logic [IB-1:0] w_idx;
    logic [OB-1:0] w_roff;
    logic [1:0]    w_way_hit, w_way_valid, w_way_dirty;
    logic [TB-1:0] w_way_tag [2];
    word_t         w_way_rdata [2];
    logic [1:0]    w_wr_en, w_meta_en;
    logic [OB-1:0] w_wr_off;
    word_t         w_wr_data;
    logic          w_meta_valid, w_meta_dirty;
    logic [TB-1:0] w_meta_tag;
    logic          w_req, w_is_wr, w_any_hit, w_hway, w_dhit;
    logic          w_wb_way, w_wc_last, w_flush_last, w_scan;
    logic          w_unused;

    assign w_req_tag = dmemaddr[31 -: TB];
    assign w_req_idx = dmemaddr[31-TB -: IB];
    assign w_req_off = dmemaddr[31-TB-IB -: OB];
    assign w_unused  = ^dmemaddr[1:0];

    // Address/offset selection, hit detection and way write controls
    always_comb begin
        w_scan       = (r_state == FLUSH_SCAN) || (r_state == FLUSH_WB);
        w_idx        = w_scan ? r_fset : w_req_idx;
        w_roff       = (r_state == IDLE) ? w_req_off : r_wc;
        w_req        = dmemREN | dmemWEN;
        w_is_wr      = dmemWEN & ~dmemREN;
        w_any_hit    = |w_way_hit;
        w_hway       = w_way_hit[1];
        w_dhit       = (r_state == IDLE) && !halt && w_req && w_any_hit;
        w_wb_way     = (r_state == FLUSH_WB) ? r_fway : r_victim;
        w_wc_last    = (r_wc == OB'(WORDS - 1));
        w_flush_last = (r_fset == IB'(SETS - 1)) && r_fway;

        w_wr_data    = (r_state == FILL) ? dload : dmemstore;
        w_wr_off     = (r_state == FILL) ? r_wc : w_req_off;
        w_meta_valid = (r_state != FLUSH_WB);
        w_meta_dirty = (r_state == IDLE);
        w_meta_tag   = (r_state == FLUSH_WB) ? w_way_tag[r_fway] : w_req_tag;
        w_wr_en      = '0;
        w_meta_en    = '0;
        if (w_dhit && w_is_wr) begin
            w_wr_en[w_hway]   = 1'b1;
            w_meta_en[w_hway] = 1'b1;
        end
        if (r_state == FILL && !dwait) begin
            w_wr_en[r_victim] = 1'b1;
            if (w_wc_last) w_meta_en[r_victim] = 1'b1;
        end
        if (r_state == FLUSH_WB && !dwait && w_wc_last) begin
            w_meta_en[r_fway] = 1'b1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_way
        assoc_dcache_way #(.SETS(SETS), .WORDS(WORDS)) u_way (
            .clk          (CLK),
            .rst          (rst),
            .i_idx        (w_idx),
            .i_tag        (w_req_tag),
            .i_roff       (w_roff),
            .i_wr_en      (w_wr_en[g]),
            .i_wr_off     (w_wr_off),
            .i_wr_data    (w_wr_data),
            .i_meta_en    (w_meta_en[g]),
            .i_meta_valid (w_meta_valid),
            .i_meta_dirty (w_meta_dirty),
            .i_meta_tag   (w_meta_tag),
            .o_hit        (w_way_hit[g]),
            .o_valid      (w_way_valid[g]),
            .o_dirty      (w_way_dirty[g]),
            .o_tag        (w_way_tag[g]),
            .o_rdata      (w_way_rdata[g])
        );
    end

    // Datapath and memory-side outputs, decoded from the registered state
    always_comb begin
        dhit     = w_dhit;
        dmemload = w_dhit ? w_way_rdata[w_hway] : '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        case (r_state)
            WB, FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = {w_way_tag[w_wb_way], w_idx, r_wc, 2'b00};
                dstore = w_way_rdata[w_wb_way];
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = {w_req_tag, w_idx, r_wc, 2'b00};
            end
`ifdef DCACHE_HITCNT_EN
            CNT_WR: begin
                dWEN   = 1'b1;
                daddr  = HIT_COUNT_ADDR;
                dstore = r_hitcnt;
            end
`endif
            DONE:    flushed = 1'b1;
            default: ;
        endcase
    end

    // Controller FSM: miss handling, LRU update, flush walk and hit counting
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wc     <= '0;
            r_victim <= 1'b0;
            r_fset   <= '0;
            r_fway   <= 1'b0;
            r_lru    <= '0;
`ifdef DCACHE_HITCNT_EN
            r_hitcnt     <= '0;
            r_after_fill <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
`ifdef DCACHE_HITCNT_EN
                    r_after_fill <= 1'b0;
`endif
                    if (halt) begin
                        r_state <= FLUSH_SCAN;
                        r_fset  <= '0;
                        r_fway  <= 1'b0;
                    end else if (w_req) begin
                        if (w_any_hit) begin
                            r_lru[w_req_idx] <= ~w_hway;
`ifdef DCACHE_HITCNT_EN
                            if (!r_after_fill) r_hitcnt <= r_hitcnt + 32'd1;
`endif
                        end else begin
                            r_victim <= r_lru[w_req_idx];
                            r_state  <= (w_way_valid[r_lru[w_req_idx]] && w_way_dirty[r_lru[w_req_idx]])
                                        ? WB : FILL;
                        end
                    end
                end
                WB: begin
                    if (!dwait) begin
                        r_wc <= r_wc + 1'b1;
                        if (w_wc_last) begin
                            r_wc    <= '0;
                            r_state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (!dwait) begin
                        r_wc <= r_wc + 1'b1;
                        if (w_wc_last) begin
                            r_wc    <= '0;
                            r_state <= IDLE;
`ifdef DCACHE_HITCNT_EN
                            r_after_fill <= 1'b1;
`endif
                        end
                    end
                end
                FLUSH_SCAN: begin
                    if (w_way_valid[r_fway] && w_way_dirty[r_fway]) begin
                        r_state <= FLUSH_WB;
                    end else if (w_flush_last) begin
                        r_state <= c_FLUSH_END;
                    end else begin
                        r_fway <= ~r_fway;
                        if (r_fway) r_fset <= r_fset + 1'b1;
                    end
                end
                FLUSH_WB: begin
                    if (!dwait) begin
                        r_wc <= r_wc + 1'b1;
                        if (w_wc_last) begin
                            r_wc <= '0;
                            if (w_flush_last) begin
                                r_state <= c_FLUSH_END;
                            end else begin
                                r_state <= FLUSH_SCAN;
                                r_fway  <= ~r_fway;
                                if (r_fway) r_fset <= r_fset + 1'b1;
                            end
                        end
                    end
                end
                CNT_WR: begin
                    if (!dwait) r_state <= DONE;
                end
                DONE:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
